main_memory: RTL and testbench
==============================

// Module: main_memory
// PURPOSE
//   Backing data memory that services the direct-mapped cache's refill/write-through traffic.
//   Single-outstanding request/response responder with a fixed programmable access latency.
//   Word-addressed over the full 15-bit space: 3-bit tag + 12-bit index.
//   Self-clears all words to zero after reset before accepting any request.
// PARAMETERS
//   ADDR_W   15  word address width; depth = 2**ADDR_W
//   DATA_W   32  data word width
//   LATENCY  4   edges from request accept to response (>=1)
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       reset: synchronous, active-high
//   req_valid  in   1       request present
//   req_ready  out  1       accepting requests (state==IDLE, combinational)
//   req_we     in   1       1=write, 0=read
//   req_addr   in   ADDR_W  word address
//   req_wdata  in   DATA_W  write data
//   resp_valid out  1       response present (registered)
//   resp_ready in   1       consumer takes response
//   resp_we    out  1       echo of request type
//   resp_rdata out  DATA_W  read data; for writes, echo of written data
// BEHAVIOUR
//   Reset (rst=1 at edge): state<=CLEAR, clr_addr<=0, cnt<=0, resp_valid<=0, resp_we<=0,
//     resp_rdata<=0. Any in-flight request is dropped; an unperformed write is never performed.
//   CLEAR: each edge mem[clr_addr]<=0, clr_addr++; at clr_addr==DEPTH-1 -> IDLE.
//     Takes exactly DEPTH cycles; req_ready=0 throughout.
//   IDLE: req_ready=1. Edge with req_valid: latch we/addr/wdata, cnt<=LATENCY-1 -> WAIT.
//   WAIT: req_ready=0. cnt!=0: cnt--. cnt==0: perform access (write: mem[addr]<=wdata,
//     resp_rdata<=wdata; read: resp_rdata<=mem[addr]); resp_valid<=1, resp_we<=we -> RESP.
//   Latency: accept at edge E0 -> access at edge E0+LATENCY -> resp_valid high after it.
//   RESP: resp_valid, resp_we, resp_rdata held stable until an edge with resp_ready=1,
//     then resp_valid<=0 -> IDLE. req_ready=0 in RESP; no back-to-back overlap.
//     Minimum request spacing = LATENCY+2 cycles.
//   req_valid outside IDLE: ignored; no buffering.
//   Address: full decode, no out-of-range case. 0 and 2**ADDR_W-1 are ordinary words.
//   Read after write to the same address returns the new data; the write is committed
//     before the read is accepted.
//   resp_rdata keeps its last value while resp_valid=0.
// STRUCTURE
//   mem_pkg: ADDR_W/DATA_W/TAG_W=3/INDEX_W=12 constants; state enum
//     {CLEAR,IDLE,WAIT,RESP}, 2 bits.
//   Sub-module mem_sp_array: single-port array, synchronous write, combinational read.
//     Write port is muxed between the clear sequencer and the request path.
//   Top: FSM, cnt (clog2(LATENCY) bits, min 1), request latch, response registers.
// TESTING (bench: ADDR_W=4, LATENCY=3 unless stated)
//   1. rst 1 cycle -> req_ready=0 for 16 cycles, then 1; resp_valid=0 throughout.
//   2. wr 0x5=0xDEADBEEF -> resp_valid 3 edges after accept, resp_we=1, rdata=0xDEADBEEF;
//      rd 0x5 -> rdata=0xDEADBEEF, resp_we=0.
//   3. rd unwritten 0x9 -> resp_rdata=0x00000000.
//   4. resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0, req_valid ignored;
//      resp_ready=1 -> IDLE next cycle.
//   5. wr 0x2=0x12345678, rst asserted in WAIT -> after re-clear, rd 0x2 returns 0.
//   6. wr 0xF=0xA5A5A5A5, wr 0x0=0x5A5A5A5A, read both back intact.
//      Repeat 2 with LATENCY=1: resp_valid after the first edge following accept.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the cache backing memory.
// Address split: TAG_W-bit tag above an INDEX_W-bit index, word addressed.
package mem_pkg;

  localparam int ADDR_W  = 15;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 3;
  localparam int INDEX_W = 12;
  localparam int LATENCY = 4;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Countdown width: must hold LATENCY-1, never narrower than one bit.
  function automatic int cnt_width(input int lat);
    int w;
    w = $clog2(lat);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_sp_array.sv
// Single-port word array: synchronous write, combinational read at the same address.
// The owner muxes the port between the clear sequencer and the request path.
module mem_sp_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/main_memory.sv
// Single-outstanding memory responder with fixed access latency; clears all words after reset.
// Latency: response valid LATENCY edges after accept; response held until resp_ready, no request overlap.
module main_memory #(
  parameter int ADDR_W  = mem_pkg::ADDR_W,
  parameter int DATA_W  = mem_pkg::DATA_W,
  parameter int LATENCY = mem_pkg::LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_we,
  output logic [DATA_W-1:0] resp_rdata
);

  import mem_pkg::*;

  localparam int                CNT_W     = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t              state;
  logic [ADDR_W-1:0]   clr_addr;
  logic [CNT_W-1:0]    cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  logic                access;
  logic                arr_we;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_wdata;
  logic [DATA_W-1:0]   arr_rdata;

  assign req_ready = (state == IDLE);
  assign access    = (state == WAIT) && (cnt == '0);

  // Writes are gated by rst so a write pending at a reset edge is never committed.
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = lat_addr;
    arr_wdata = lat_wdata;
    if (state == CLEAR) begin
      arr_we    = !rst;
      arr_addr  = clr_addr;
      arr_wdata = '0;
    end else if (access && lat_we) begin
      arr_we = !rst;
    end
  end

  mem_sp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= CNT_INIT;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Writes echo their own data so the consumer sees what was committed.
            resp_rdata <= lat_we ? lat_wdata : arr_rdata;
            resp_we    <= lat_we;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// Randomized bench for main_memory: unit 0 uses LATENCY=3, unit 1 LATENCY=1, both 16 words.
// A plain word array models memory contents; latency and handshake rules are checked directly.
module tb_main_memory;

  localparam int N_WORDS = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [3:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic        resp_we    [2];
  logic [31:0] resp_rdata [2];

  int          lat_of [2] = '{3, 1};
  logic [31:0] mdl [2][N_WORDS];
  int          n_tests = 0;
  int          n_fail  = 0;

  main_memory #(.ADDR_W(4), .DATA_W(32), .LATENCY(3)) u_mem_lat3 (
    .clk        (clk),
    .rst        (rst[0]),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_we     (req_we[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .resp_valid (resp_valid[0]),
    .resp_ready (resp_ready[0]),
    .resp_we    (resp_we[0]),
    .resp_rdata (resp_rdata[0])
  );

  main_memory #(.ADDR_W(4), .DATA_W(32), .LATENCY(1)) u_mem_lat1 (
    .clk        (clk),
    .rst        (rst[1]),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_we     (req_we[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .resp_valid (resp_valid[1]),
    .resp_ready (resp_ready[1]),
    .resp_we    (resp_we[1]),
    .resp_rdata (resp_rdata[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One-cycle reset, then the clear sweep must hold req_ready low for exactly 16 cycles.
  task automatic do_reset(input int u);
    @(negedge clk);
    rst[u]        = 1'b1;
    req_valid[u]  = 1'b0;
    resp_ready[u] = 1'b0;
    @(negedge clk);
    rst[u] = 1'b0;
    for (int a = 0; a < N_WORDS; a++) mdl[u][a] = 32'h0;
    check("rst_rdata", resp_rdata[u], 32'h0);
    check("rst_resp_we", {31'b0, resp_we[u]}, 32'h0);
    for (int i = 0; i < N_WORDS; i++) begin
      check("clear_req_ready", {31'b0, req_ready[u]}, 32'h0);
      check("clear_resp_valid", {31'b0, resp_valid[u]}, 32'h0);
      @(negedge clk);
    end
    check("post_clear_req_ready", {31'b0, req_ready[u]}, 32'h1);
  endtask

  task automatic wait_ready(input int u);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", {31'b0, req_ready[u]}, 32'h1);
  endtask

  task automatic do_req(input int u, input logic we, input logic [3:0] addr,
                        input logic [31:0] data, input int hold);
    logic [31:0] exp;
    int          n;
    wait_ready(u);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_wdata[u] = data;
    @(posedge clk);
    #1;
    req_valid[u] = 1'b0;
    exp = we ? data : mdl[u][addr];
    if (we) mdl[u][addr] = data;
    n = 0;
    while (!resp_valid[u] && n < 20) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("latency", 32'(n), 32'(lat_of[u]));
    check("resp_we", {31'b0, resp_we[u]}, {31'b0, we});
    check("resp_rdata", resp_rdata[u], exp);
    // Stall the consumer while offering stray writes that must be ignored.
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_valid[u] = 1'b1;
      req_we[u]    = 1'b1;
      req_addr[u]  = 4'($urandom_range(0, N_WORDS - 1));
      req_wdata[u] = $urandom;
      check("hold_resp_valid", {31'b0, resp_valid[u]}, 32'h1);
      check("hold_rdata", resp_rdata[u], exp);
      check("hold_req_ready", {31'b0, req_ready[u]}, 32'h0);
    end
    @(negedge clk);
    req_valid[u]  = 1'b0;
    resp_ready[u] = 1'b1;
    check("pre_take_resp_valid", {31'b0, resp_valid[u]}, 32'h1);
    @(negedge clk);
    resp_ready[u] = 1'b0;
    check("post_take_resp_valid", {31'b0, resp_valid[u]}, 32'h0);
    check("post_take_req_ready", {31'b0, req_ready[u]}, 32'h1);
    check("post_take_rdata_kept", resp_rdata[u], exp);
  endtask

  // Write accepted, then reset lands while it is still counting down: it must be lost.
  task automatic write_then_reset(input int u, input logic [3:0] addr, input logic [31:0] data);
    wait_ready(u);
    req_valid[u] = 1'b1;
    req_we[u]    = 1'b1;
    req_addr[u]  = addr;
    req_wdata[u] = data;
    @(posedge clk);
    #1;
    req_valid[u] = 1'b0;
    check("wait_resp_valid", {31'b0, resp_valid[u]}, 32'h0);
    do_reset(u);
  endtask

  task automatic random_ops(input int u, input int count);
    for (int k = 0; k < count; k++) begin
      do_req(u, 1'($urandom_range(0, 1)), 4'($urandom_range(0, N_WORDS - 1)),
             $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u]        = 1'b1;
      req_valid[u]  = 1'b0;
      req_we[u]     = 1'b0;
      req_addr[u]   = 4'h0;
      req_wdata[u]  = 32'h0;
      resp_ready[u] = 1'b0;
    end

    do_reset(0);
    do_reset(1);

    do_req(0, 1'b1, 4'h5, 32'hDEADBEEF, 0);
    do_req(0, 1'b0, 4'h5, 32'h0, 2);
    do_req(0, 1'b0, 4'h9, 32'h0, 0);
    do_req(0, 1'b0, 4'h5, 32'h0, 5);
    write_then_reset(0, 4'h2, 32'h12345678);
    do_req(0, 1'b0, 4'h2, 32'h0, 0);
    do_req(0, 1'b1, 4'hF, 32'hA5A5A5A5, 1);
    do_req(0, 1'b1, 4'h0, 32'h5A5A5A5A, 0);
    do_req(0, 1'b0, 4'hF, 32'h0, 0);
    do_req(0, 1'b0, 4'h0, 32'h0, 3);
    random_ops(0, 40);
    for (int a = 0; a < N_WORDS; a++) do_req(0, 1'b0, 4'(a), 32'h0, 0);

    do_req(1, 1'b1, 4'h5, 32'hDEADBEEF, 0);
    do_req(1, 1'b0, 4'h5, 32'h0, 1);
    do_req(1, 1'b0, 4'h9, 32'h0, 0);
    random_ops(1, 25);
    for (int a = 0; a < N_WORDS; a++) do_req(1, 1'b0, 4'(a), 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
